// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/flag controller for a 2**ADDR_W deep FIFO in an external SRAM; optional sticky error flags under FIFO_CTRL_ERR_EN
module fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 14
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iPush,
  input  logic              iPop,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oAlmostFull,
`ifdef FIFO_CTRL_ERR_EN
  output logic [ADDR_W:0]   oCount,
  output logic              oOvf,
  output logic              oUdf
`else
  output logic [ADDR_W:0]   oCount
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_THR  = AF_LVL[ADDR_W:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic            empty;
  logic            full;
  logic            push_acc;
  logic            pop_acc;

  // Occupancy and flags all come from the same pointer pair, so they always agree.
  always_comb begin
    count    = wr_ptr - rd_ptr;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
               (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    pop_acc  = iPop & ~empty;
    // A push into a full FIFO is fine when the head is leaving in the same cycle.
    push_acc = iPush & (~full | pop_acc);
  end

  // Write/read pointer advance; reset drops all stored occupancy immediately.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // SRAM strobes and status; write enable is masked while reset is held.
  always_comb begin
    oWrEn       = push_acc & ~iRst;
    oRdEn       = ~empty & ~iRst;
    oWrAddr     = wr_ptr[ADDR_W-1:0];
    oRdAddr     = rd_ptr[ADDR_W-1:0];
    oFull       = full;
    oEmpty      = empty;
    oAlmostFull = (count >= AF_THR);
    oCount      = count;
  end

`ifdef FIFO_CTRL_ERR_EN
  // Sticky overflow/underflow: set on any rejected request, held until reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oOvf <= 1'b0;
      oUdf <= 1'b0;
    end else begin
      if (iPush && !push_acc) oOvf <= 1'b1;
      if (iPop  && !pop_acc)  oUdf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl with SRAM model; checks error flags when FIFO_CTRL_ERR_EN is defined
module tb_fifo_ctrl;

  localparam int ADDR_W = 4;
  localparam int AF_LVL = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              iRst;
  logic              iPush;
  logic              iPop;
  logic              oWrEn;
  logic [ADDR_W-1:0] oWrAddr;
  logic              oRdEn;
  logic [ADDR_W-1:0] oRdAddr;
  logic              oFull;
  logic              oEmpty;
  logic              oAlmostFull;
  logic [ADDR_W:0]   oCount;
`ifdef FIFO_CTRL_ERR_EN
  logic              oOvf;
  logic              oUdf;
`endif

  logic [7:0] wdata;
  logic [7:0] sram [DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: occupancy, lifetime push/pop totals, expected data queue.
  int         cnt_m  = 0;
  int         wtot_m = 0;
  int         rtot_m = 0;
  bit         ovf_m  = 0;
  bit         udf_m  = 0;
  logic [7:0] exp_q[$];

  fifo_ctrl #(.ADDR_W(ADDR_W), .AF_LVL(AF_LVL)) dut (
    .iClk        (clk),
    .iRst        (iRst),
    .iPush       (iPush),
    .iPop        (iPop),
    .oWrEn       (oWrEn),
    .oWrAddr     (oWrAddr),
    .oRdEn       (oRdEn),
    .oRdAddr     (oRdAddr),
    .oFull       (oFull),
    .oEmpty      (oEmpty),
    .oAlmostFull (oAlmostFull),
`ifdef FIFO_CTRL_ERR_EN
    .oCount      (oCount),
    .oOvf        (oOvf),
    .oUdf        (oUdf)
`else
    .oCount      (oCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SRAM: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (oWrEn) sram[oWrAddr] <= wdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT presents head data and the consumer takes it,
  // compare the SRAM read port against the oldest expected word.
  always @(negedge clk) begin
    #3;
    if (!iRst && iPop && oRdEn) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", 1, 0);
      else                   chk("rd_data", int'(sram[oRdAddr]), int'(exp_q.pop_front()));
    end
  end

  task automatic check_status();
    chk("count", int'(oCount), cnt_m);
    chk("empty", int'(oEmpty), int'(cnt_m == 0));
    chk("full",  int'(oFull),  int'(cnt_m == DEPTH));
    chk("afull", int'(oAlmostFull), int'(cnt_m >= AF_LVL));
    chk("rden",  int'(oRdEn),  int'(cnt_m != 0));
    chk("wraddr", int'(oWrAddr), wtot_m % DEPTH);
    chk("rdaddr", int'(oRdAddr), rtot_m % DEPTH);
`ifdef FIFO_CTRL_ERR_EN
    chk("ovf", int'(oOvf), int'(ovf_m));
    chk("udf", int'(oUdf), int'(udf_m));
`endif
  endtask

  task automatic cycle(input bit push, input bit pop, input logic [7:0] d);
    bit a_pop;
    bit a_push;
    @(negedge clk);
    #1;
    iPush = push;
    iPop  = pop;
    wdata = d;
    a_pop  = pop && (cnt_m > 0);
    a_push = push && ((cnt_m < DEPTH) || a_pop);
    #1;
    check_status();
    chk("wren", int'(oWrEn), int'(a_push));
    @(posedge clk);
    if (a_push) begin
      exp_q.push_back(d);
      wtot_m++;
      cnt_m++;
    end
    if (a_pop) begin
      rtot_m++;
      cnt_m--;
    end
    if (push && !a_push) ovf_m = 1;
    if (pop && !a_pop)   udf_m = 1;
  endtask

  task automatic model_reset();
    cnt_m  = 0;
    wtot_m = 0;
    rtot_m = 0;
    ovf_m  = 0;
    udf_m  = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_count", int'(oCount), 0);
    chk("rst_empty", int'(oEmpty), 1);
    chk("rst_full",  int'(oFull), 0);
    chk("rst_afull", int'(oAlmostFull), 0);
    chk("rst_wren",  int'(oWrEn), 0);
    chk("rst_rden",  int'(oRdEn), 0);
    chk("rst_wraddr", int'(oWrAddr), 0);
    chk("rst_rdaddr", int'(oRdAddr), 0);
`ifdef FIFO_CTRL_ERR_EN
    chk("rst_ovf", int'(oOvf), 0);
    chk("rst_udf", int'(oUdf), 0);
`endif
  endtask

  initial begin
    iRst  = 1'b1;
    iPush = 1'b1;
    iPop  = 1'b0;
    wdata = 8'h00;
    #2;
    check_reset_vals();
    @(negedge clk);
    #1;
    iPush = 1'b0;
    iRst  = 1'b0;
    model_reset();

    // Fill with 0x00..0x0F, then a rejected 17th push of 0xAA.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'(i));
    cycle(1, 0, 8'hAA);
    cycle(0, 0, 8'h00);

    // Drain in order, then a rejected pop on empty.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // Push+pop on empty is push only; push+pop on full keeps it full.
    cycle(1, 1, 8'h31);
    cycle(0, 0, 8'h00);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1, 0, 8'(8'h40 + i));
    cycle(1, 1, 8'h5E);
    cycle(0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);

    // 20 pushes with 4 interleaved pops, exercising address wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 8'(8'h80 + i));
      if (i % 5 == 4) cycle(0, 1, 8'h00);
    end
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45), 8'($urandom));

    // Asynchronous reset mid-burst at occupancy 7.
    cycle(0, 0, 8'h00);
    iRst = 1'b1;
    @(negedge clk);
    #1;
    iRst = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) cycle(1, 0, 8'(8'hC0 + i));
    @(negedge clk);
    #1;
    iPush = 1'b1;
    wdata = 8'hEE;
    chk("pre_rst_count", int'(oCount), 7);
    #1;
    iRst = 1'b1;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    #1;
    iPush = 1'b0;
    iRst  = 1'b0;
    cycle(0, 0, 8'h00);
    cycle(0, 1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
